sram_sp_masked_ext: RTL and testbench
=====================================

Name: sram_sp_masked_ext

Overview:
- Parametrised single-port synchronous RAM model. Successor to the fixed 4096x32 unmasked macro models used by the memory generator.
- Adds per-segment write masking, selectable read latency (1 or 2), held read data with a valid strobe, and a hardware zero-fill sequencer after reset.
- Instantiated wherever a generated single-port array needs deterministic contents after reset.

Parameters:
- DEPTH, 4096: number of words; any value >= 2, need not be a power of 2.
- WIDTH, 32: word width in bits.
- MASK_GRAN, 8: bits per write-mask segment; WIDTH must be a multiple of MASK_GRAN.
- OUT_REG, 0: 0 gives read latency 1; 1 adds an output register, giving read latency 2.
- INIT_ZERO, 1: 1 zero-fills the whole array after reset; 0 makes the block ready immediately.
- Derived (localparam): AW = max(1, clog2(DEPTH)); SEG = WIDTH/MASK_GRAN.

Ports:
- RW0_clk  in  1  clock; all state changes on the rising edge.
- RW0_rst_n  in  1  asynchronous, active-low reset.
- RW0_addr  in  AW  word address.
- RW0_en  in  1  request enable.
- RW0_wmode  in  1  1 = write, 0 = read.
- RW0_wmask  in  SEG  write-enable per segment; bit i covers wdata[i*MASK_GRAN +: MASK_GRAN].
- RW0_wdata  in  WIDTH  write data.
- RW0_rdata  out  WIDTH  read data; holds its value between reads.
- RW0_rvalid  out  1  one-cycle strobe marking new RW0_rdata.
- RW0_ready  out  1  high when requests are accepted.

Behaviour:
- Reset (async assert):
  - RW0_rdata = 0, RW0_rvalid = 0, all pipeline registers and the init counter cleared.
  - State goes to INIT if INIT_ZERO = 1, otherwise READY.
  - RW0_ready = 0 in INIT, 1 in READY.
  - Array contents are not touched by reset itself.
- State machine, states INIT and READY:
  - INIT: counter ic runs 0..DEPTH-1, one word per cycle. ram[ic] is written with all zeros, ignoring mask.
  - INIT takes exactly DEPTH cycles after reset deassertion. READY is entered, and RW0_ready rises, on the edge after the write to DEPTH-1.
  - READY: terminal state; left only by reset.
- Requests in INIT, or in any cycle with RW0_ready = 0, are dropped: not queued, no write, no rvalid.
- Accepted request = RW0_en && RW0_ready.
- Write (accepted, RW0_wmode = 1):
  - For each i with RW0_wmask[i] = 1, ram[addr] segment i takes wdata segment i. Other segments keep their value.
  - A write with an all-zero mask is a no-op.
- Read (accepted, RW0_wmode = 0):
  - ram[addr] is sampled at the request edge. The array is single-port, so no same-cycle write exists.
  - OUT_REG = 0: RW0_rdata updates and RW0_rvalid = 1 in cycle N+1 for a request in cycle N.
  - OUT_REG = 1: both appear in cycle N+2.
  - Back-to-back reads give back-to-back rvalid pulses, one per read, in order.
- Hold: RW0_rdata is unchanged in any cycle without rvalid, including cycles with writes. A later write to the same address does not alter held rdata.
- Read-after-write: a read in cycle N+1 of an address written in cycle N returns the new data.
- Out of range (addr >= DEPTH, non-power-of-2 DEPTH only):
  - Writes are dropped.
  - Reads return 0 with a normal rvalid.
- Reset mid-operation: in-flight reads are discarded (no rvalid after reset). A reset during INIT restarts the sequencer at 0.
- Simulation-only RANDOMIZE_MEM_INIT preload of the array is kept. With INIT_ZERO = 1 the preload is overwritten by the sequencer.

Test Plan:
- Zero-fill timing: DEPTH = 16, INIT_ZERO = 1, release reset -> RW0_ready low exactly 16 cycles then high; reading all 16 addresses returns 0x00000000 each, one rvalid per read.
- Masked write: write 0xAABBCCDD with mask 4'b1111 to addr 5, then 0x11223344 with mask 4'b0101 -> read addr 5 returns 0xAA22CC44.
- Latency and hold: OUT_REG = 1, read addr 5 in cycle N -> rvalid only in N+2 with 0xAA22CC44; write 0 to addr 5 in N+3 -> rdata stays 0xAA22CC44 until the next read.
- Dropped during INIT: issue a write of 0xFFFFFFFF to addr 3 during INIT -> after ready, addr 3 reads 0, and no rvalid is seen during INIT.
- Out of range: DEPTH = 12, write 0x1234 to addr 13 then read addr 13 -> rdata 0 with rvalid; addr 1 (13 mod 12) is unchanged.
- Reset mid-read and mid-INIT: assert RW0_rst_n low one cycle after a read -> no rvalid, rdata = 0; deassert -> full DEPTH-cycle INIT again.

Source files
------------

// File: rtl/sram_sp_masked_ext.sv
// Single-port synchronous RAM model with per-segment write mask, 1- or 2-cycle
// read latency, held read data with a valid strobe, and post-reset zero-fill.
module sram_sp_masked_ext #(
    parameter int DEPTH     = 4096,
    parameter int WIDTH     = 32,
    parameter int MASK_GRAN = 8,
    parameter int OUT_REG   = 0,
    parameter int INIT_ZERO = 1,
    localparam int AW  = ($clog2(DEPTH) < 1) ? 1 : $clog2(DEPTH),
    localparam int SEG = WIDTH / MASK_GRAN
) (
    input  logic             RW0_clk,
    input  logic             RW0_rst_n,
    input  logic [AW-1:0]    RW0_addr,
    input  logic             RW0_en,
    input  logic             RW0_wmode,
    input  logic [SEG-1:0]   RW0_wmask,
    input  logic [WIDTH-1:0] RW0_wdata,
    output logic [WIDTH-1:0] RW0_rdata,
    output logic             RW0_rvalid,
    output logic             RW0_ready
);

    typedef enum logic {ST_INIT, ST_READY} state_t;

    // DEPTH always fits in AW+1 bits, so the range check needs no 32-bit widening.
    localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);

    state_t          state_q, state_d;
    logic [AW-1:0]   ic_q, ic_d;
    logic            ready;
    logic            init_we;

    logic [WIDTH-1:0] ram [DEPTH];

    logic             acc;
    logic             in_range;
    logic             mem_we;
    logic [AW-1:0]    mem_waddr;
    logic [WIDTH-1:0] mem_wdata;
    logic [SEG-1:0]   mem_wbe;
    logic [WIDTH-1:0] rd_word;

    logic             rd_vld_p0_q, rd_vld_p0_d;
    logic [WIDTH-1:0] rd_data_p0_q, rd_data_p0_d;
    logic             rd_vld_p1_q, rd_vld_p1_d;
    logic [WIDTH-1:0] rd_data_p1_q, rd_data_p1_d;

    always_ff @(posedge RW0_clk or negedge RW0_rst_n) begin
        if (!RW0_rst_n) begin
            if (INIT_ZERO != 0) state_q <= ST_INIT;
            else                state_q <= ST_READY;
            ic_q <= '0;
        end else begin
            state_q <= state_d;
            ic_q    <= ic_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ic_d    = ic_q;
        if (state_q == ST_INIT) begin
            ic_d = ic_q + 1'b1;
            if (ic_q == AW'(DEPTH - 1)) begin
                state_d = ST_READY;
                ic_d    = '0;
            end
        end
    end

    always_comb begin
        ready   = (state_q == ST_READY);
        init_we = (state_q == ST_INIT);
    end

    assign RW0_ready = ready;

    always_comb begin
        acc      = RW0_en && ready;
        in_range = ({1'b0, RW0_addr} < DEPTH_W);
        rd_word  = in_range ? ram[RW0_addr] : '0;

        mem_we    = 1'b0;
        mem_waddr = RW0_addr;
        mem_wdata = RW0_wdata;
        mem_wbe   = RW0_wmask;
        // The zero-fill sequencer owns the write port while initialising.
        if (init_we) begin
            mem_we    = 1'b1;
            mem_waddr = ic_q;
            mem_wdata = '0;
            mem_wbe   = '1;
        end else if (acc && RW0_wmode && in_range) begin
            mem_we = 1'b1;
        end
    end

    always_ff @(posedge RW0_clk) begin
        if (mem_we) begin
            for (int i = 0; i < SEG; i++) begin
                if (mem_wbe[i])
                    ram[mem_waddr][i*MASK_GRAN +: MASK_GRAN] <= mem_wdata[i*MASK_GRAN +: MASK_GRAN];
            end
        end
    end

`ifdef RANDOMIZE_MEM_INIT
    // Simulation-only garbage preload; the zero-fill sequencer overwrites it.
    initial begin
        for (int i = 0; i < DEPTH; i++)
            for (int b = 0; b < WIDTH; b++)
                ram[i][b] = 1'($urandom);
    end
`endif

    always_comb begin
        rd_vld_p0_d  = acc && !RW0_wmode;
        rd_data_p0_d = rd_vld_p0_d ? rd_word : rd_data_p0_q;
        rd_vld_p1_d  = rd_vld_p0_q;
        rd_data_p1_d = rd_vld_p0_q ? rd_data_p0_q : rd_data_p1_q;
    end

    // Stage p0: array sample; stage p1: optional output register.
    always_ff @(posedge RW0_clk or negedge RW0_rst_n) begin
        if (!RW0_rst_n) begin
            rd_vld_p0_q  <= 1'b0;
            rd_data_p0_q <= '0;
            rd_vld_p1_q  <= 1'b0;
            rd_data_p1_q <= '0;
        end else begin
            rd_vld_p0_q  <= rd_vld_p0_d;
            rd_data_p0_q <= rd_data_p0_d;
            rd_vld_p1_q  <= rd_vld_p1_d;
            rd_data_p1_q <= rd_data_p1_d;
        end
    end

    assign RW0_rdata  = (OUT_REG != 0) ? rd_data_p1_q : rd_data_p0_q;
    assign RW0_rvalid = (OUT_REG != 0) ? rd_vld_p1_q  : rd_vld_p0_q;

endmodule

// File: tb/tb_sram_sp_masked_ext.sv
// Bench for sram_sp_masked_ext: two instances (DEPTH 16 latency 1, DEPTH 12
// latency 2) share one stimulus stream and are checked against a scoreboard model.
module tb_sram_sp_masked_ext;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        wmode = 1'b0;
    logic [3:0]  addr = '0;
    logic [3:0]  wmask = '0;
    logic [31:0] wdata = '0;

    logic [31:0] rdata_a, rdata_b;
    logic        rvalid_a, rvalid_b;
    logic        ready_a, ready_b;

    always #5 clk = ~clk;

    sram_sp_masked_ext #(.DEPTH(16), .WIDTH(32), .MASK_GRAN(8), .OUT_REG(0), .INIT_ZERO(1)) u_dut_a (
        .RW0_clk(clk), .RW0_rst_n(rst_n), .RW0_addr(addr), .RW0_en(en),
        .RW0_wmode(wmode), .RW0_wmask(wmask), .RW0_wdata(wdata),
        .RW0_rdata(rdata_a), .RW0_rvalid(rvalid_a), .RW0_ready(ready_a)
    );

    sram_sp_masked_ext #(.DEPTH(12), .WIDTH(32), .MASK_GRAN(8), .OUT_REG(1), .INIT_ZERO(1)) u_dut_b (
        .RW0_clk(clk), .RW0_rst_n(rst_n), .RW0_addr(addr), .RW0_en(en),
        .RW0_wmode(wmode), .RW0_wmask(wmask), .RW0_wdata(wdata),
        .RW0_rdata(rdata_b), .RW0_rvalid(rvalid_b), .RW0_ready(ready_b)
    );

    typedef struct {
        logic [31:0] data;
        int          due;
    } sb_t;

    sb_t         sbq [2][$];
    logic [31:0] mem_m [2][16];
    int          depth_m [2] = '{16, 12};
    int          lat_m [2]   = '{1, 2};
    int          init_cnt [2] = '{0, 0};
    logic [31:0] held [2] = '{32'd0, 32'd0};
    int          edge_n = 0;
    int          n_checks = 0;
    int          n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s t=%0t got=%h exp=%h", tag, $time, got, exp);
        end
    endtask

    task automatic model_step(input int d);
        sb_t it;
        if (!rst_n) begin
            init_cnt[d] = 0;
            sbq[d].delete();
            held[d] = '0;
        end else if (init_cnt[d] < depth_m[d]) begin
            mem_m[d][init_cnt[d]] = '0;
            init_cnt[d]++;
        end else if (en) begin
            if (wmode) begin
                if (int'(addr) < depth_m[d]) begin
                    for (int s = 0; s < 4; s++)
                        if (wmask[s]) mem_m[d][addr][s*8 +: 8] = wdata[s*8 +: 8];
                end
            end else begin
                it.data = (int'(addr) < depth_m[d]) ? mem_m[d][addr] : 32'd0;
                it.due  = edge_n + lat_m[d] - 1;
                sbq[d].push_back(it);
            end
        end
    endtask

    task automatic check_outputs(input int d);
        logic [31:0] rd;
        logic        rv, rdy, exp_v, exp_rdy;
        sb_t         it;
        rd  = (d == 0) ? rdata_a  : rdata_b;
        rv  = (d == 0) ? rvalid_a : rvalid_b;
        rdy = (d == 0) ? ready_a  : ready_b;
        exp_rdy = (init_cnt[d] >= depth_m[d]);
        exp_v   = (sbq[d].size() > 0) && (sbq[d][0].due == edge_n);
        chk($sformatf("ready_%0d", d), {31'd0, rdy}, {31'd0, exp_rdy});
        chk($sformatf("rvalid_%0d", d), {31'd0, rv}, {31'd0, exp_v});
        if (exp_v) begin
            it = sbq[d].pop_front();
            held[d] = it.data;
        end
        chk($sformatf("rdata_%0d", d), rd, held[d]);
    endtask

    // Model advances on the same edge as the DUTs; outputs are compared 1 ns later.
    always @(posedge clk) begin
        edge_n++;
        for (int d = 0; d < 2; d++) model_step(d);
        #1;
        for (int d = 0; d < 2; d++) check_outputs(d);
    end

    task automatic op(input logic e, input logic w, input logic [3:0] a,
                      input logic [3:0] m, input logic [31:0] dt);
        en = e; wmode = w; addr = a; wmask = m; wdata = dt;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) op(1'b0, 1'b0, 4'd0, 4'd0, 32'd0);
    endtask

    initial begin
        @(negedge clk);
        idle(3);

        // Release reset with requests that must be dropped while initialising.
        rst_n = 1'b1;
        op(1'b1, 1'b1, 4'd3, 4'hF, 32'hFFFF_FFFF);
        op(1'b1, 1'b0, 4'd3, 4'h0, 32'd0);
        op(1'b1, 1'b1, 4'd5, 4'hF, 32'hDEAD_BEEF);
        idle(20);

        for (int a = 0; a < 16; a++) op(1'b1, 1'b0, 4'(a), 4'h0, 32'd0);
        idle(3);

        op(1'b1, 1'b1, 4'd5, 4'hF, 32'hAABB_CCDD);
        op(1'b1, 1'b1, 4'd5, 4'b0101, 32'h1122_3344);
        op(1'b1, 1'b0, 4'd5, 4'h0, 32'd0);
        idle(2);
        op(1'b1, 1'b1, 4'd5, 4'hF, 32'd0);
        idle(3);
        op(1'b1, 1'b0, 4'd5, 4'h0, 32'd0);
        idle(3);

        op(1'b1, 1'b1, 4'd6, 4'hF, 32'h5A5A_5A5A);
        op(1'b1, 1'b1, 4'd6, 4'h0, 32'hFFFF_FFFF);
        op(1'b1, 1'b0, 4'd6, 4'h0, 32'd0);
        idle(3);

        op(1'b1, 1'b1, 4'd1, 4'hF, 32'hCAFE_0001);
        op(1'b1, 1'b1, 4'd13, 4'hF, 32'h0000_1234);
        op(1'b1, 1'b0, 4'd13, 4'h0, 32'd0);
        op(1'b1, 1'b0, 4'd1, 4'h0, 32'd0);
        idle(3);

        op(1'b1, 1'b1, 4'd7, 4'hF, 32'h0102_0304);
        op(1'b1, 1'b0, 4'd7, 4'h0, 32'd0);
        op(1'b1, 1'b1, 4'd7, 4'b1000, 32'hFF00_0000);
        op(1'b1, 1'b0, 4'd7, 4'h0, 32'd0);
        op(1'b1, 1'b0, 4'd7, 4'h0, 32'd0);
        idle(3);

        repeat (300) begin
            op(($urandom_range(0, 3) != 0), 1'($urandom), 4'($urandom_range(0, 15)),
               4'($urandom_range(0, 15)), $urandom);
        end
        idle(3);

        // Reset one cycle after a read, then again part-way through initialisation.
        op(1'b1, 1'b0, 4'd1, 4'h0, 32'd0);
        rst_n = 1'b0;
        idle(2);
        rst_n = 1'b1;
        idle(5);
        rst_n = 1'b0;
        idle(1);
        rst_n = 1'b1;
        op(1'b1, 1'b1, 4'd1, 4'hF, 32'h7777_7777);
        idle(20);
        for (int a = 0; a < 4; a++) op(1'b1, 1'b0, 4'(a), 4'h0, 32'd0);
        idle(4);

        chk("sb_empty_0", 32'(sbq[0].size()), 32'd0);
        chk("sb_empty_1", 32'(sbq[1].size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
